aes_key_expander: RTL and testbench

//  Iterative AES-128 key schedule that sits directly upstream of the per-round datapath.

---
 rtl/aes_key_expander_if.sv | 24 ++
 rtl/aes_key_expander.sv | 110 +++++++++++
 tb/tb_aes_key_expander.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/aes_key_expander_if.sv
// Key-load handshake and round-key read port of the AES-128 key expander.
// The master side offers keys and indexes round keys; the slave side is the expander.
interface aes_key_expander_if #(
  parameter int unsigned KEY_W = 128
) ();
  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key_in;
  logic             busy;
  logic             keys_valid;
  logic             dec;
  logic [3:0]       rk_idx;
  logic [KEY_W-1:0] roundkey;

  modport master (
    output key_valid, key_in, dec, rk_idx,
    input  key_ready, busy, keys_valid, roundkey
  );

  modport slave (
    input  key_valid, key_in, dec, rk_idx,
    output key_ready, busy, keys_valid, roundkey
  );
endinterface

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: one round key per cycle into an (NR+1)-entry store,
// served combinationally in forward (encrypt) or reversed (decrypt) order.
module aes_key_expander #(
  parameter int unsigned NR    = 10,
  parameter int unsigned KEY_W = 128
) (
  input logic               clk,
  input logic               rst_n,
  aes_key_expander_if.slave bus
);

  // Forward S-box, byte 0x00 in the top 8 bits.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_e           state_q;
  logic [3:0]       ctr_q;
  logic [7:0]       rcon_q;
  logic             key_ready_q;
  logic             busy_q;
  logic             keys_valid_q;
  logic [KEY_W-1:0] slot_q [NR+1];

  logic [3:0]       prev_idx;
  logic [KEY_W-1:0] prev_key;
  logic [KEY_W-1:0] next_key;
  logic [31:0]      w0, w1, w2, w3, t;
  logic [3:0]       eff;

  // One FIPS-197 round of the key schedule from the previous slot.
  always_comb begin
    prev_idx = (ctr_q == 4'd0) ? 4'd0 : ctr_q - 4'd1;
    prev_key = slot_q[prev_idx];
    {w0, w1, w2, w3} = prev_key;
    t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
        ^ {rcon_q, 24'h0};
    next_key[127:96] = w0 ^ t;
    next_key[95:64]  = w1 ^ next_key[127:96];
    next_key[63:32]  = w2 ^ next_key[95:64];
    next_key[31:0]   = w3 ^ next_key[63:32];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ctr_q        <= 4'd0;
      rcon_q       <= 8'h01;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StReady: begin
          if (bus.key_valid) begin
            slot_q[0]    <= bus.key_in;
            ctr_q        <= 4'd1;
            rcon_q       <= 8'h01;
            state_q      <= StExpand;
            key_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            keys_valid_q <= 1'b0;
          end
        end
        StExpand: begin
          slot_q[ctr_q] <= next_key;
          rcon_q        <= xtime(rcon_q);
          if (ctr_q == 4'(NR)) begin
            ctr_q        <= 4'd0;
            state_q      <= StReady;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b1;
          end else begin
            ctr_q <= ctr_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.key_ready  = key_ready_q;
  assign bus.busy       = busy_q;
  assign bus.keys_valid = keys_valid_q;

  // Read port is live in every state; out-of-range indices return zero.
  always_comb begin
    eff = bus.dec ? 4'(NR) - bus.rk_idx : bus.rk_idx;
    bus.roundkey = (bus.rk_idx > 4'(NR)) ? '0 : slot_q[eff];
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 and all-zero key vectors.
module tb_aes_key_expander;

  localparam logic [127:0] KeyFips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsR1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsR2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FipsR10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZeroR1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZeroR2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  aes_key_expander_if bus ();

  aes_key_expander dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic read_rk(input string tag, input logic d, input logic [3:0] idx,
                         input logic [127:0] exp);
    bus.dec    = d;
    bus.rk_idx = idx;
    @(negedge clk);
    check_eq(tag, bus.roundkey, exp);
  endtask

  // Offers a one-cycle key, optionally pulses a second key at EXPAND edge glitch_at,
  // then checks handshake, busy duration and keys_valid latency.
  task automatic load_key(input string tag, input logic [127:0] key, input int glitch_at);
    int edges;
    int busy_n;
    check_eq({tag, "_rdy_before"}, 128'(bus.key_ready), 128'd1);
    bus.key_in    = key;
    bus.key_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    edges  = 1;
    busy_n = int'(bus.busy);
    check_eq({tag, "_kv_drop"}, 128'(bus.keys_valid), 128'd0);
    check_eq({tag, "_rdy_low"}, 128'(bus.key_ready), 128'd0);
    while (!bus.keys_valid && edges < 40) begin
      if (edges == glitch_at) begin
        bus.key_in    = ~key;
        bus.key_valid = 1'b1;
      end else begin
        bus.key_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
      busy_n += int'(bus.busy);
    end
    bus.key_valid = 1'b0;
    check_eq({tag, "_edges"}, 128'(edges), 128'd11);
    check_eq({tag, "_busy_cyc"}, 128'(busy_n), 128'd10);
    check_eq({tag, "_rdy_after"}, 128'(bus.key_ready), 128'd1);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_in    = '0;
    bus.dec       = 1'b0;
    bus.rk_idx    = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: reset then idle
    check_eq("rst_kv", 128'(bus.keys_valid), 128'd0);
    check_eq("rst_busy", 128'(bus.busy), 128'd0);
    check_eq("rst_rdy", 128'(bus.key_ready), 128'd1);

    // 2: FIPS-197 key, forward order
    load_key("fips", KeyFips, 0);
    read_rk("enc_r0", 1'b0, 4'd0, KeyFips);
    read_rk("enc_r1", 1'b0, 4'd1, FipsR1);
    read_rk("enc_r2", 1'b0, 4'd2, FipsR2);
    read_rk("enc_r10", 1'b0, 4'd10, FipsR10);

    // 3: reversed order and out-of-range indices
    read_rk("dec_r0", 1'b1, 4'd0, FipsR10);
    read_rk("dec_r9", 1'b1, 4'd9, FipsR1);
    read_rk("dec_r10", 1'b1, 4'd10, KeyFips);
    for (int i = 11; i < 16; i++) begin
      read_rk($sformatf("dec_oor%0d", i), 1'b1, 4'(i), 128'd0);
    end
    read_rk("enc_oor15", 1'b0, 4'd15, 128'd0);

    // 4: second key pulsed during EXPAND is ignored
    load_key("glitch", KeyFips, 4);
    read_rk("glitch_r10", 1'b0, 4'd10, FipsR10);
    read_rk("glitch_r1", 1'b0, 4'd1, FipsR1);

    // 5: rekey from READY with the all-zero key
    load_key("zero", 128'd0, 0);
    read_rk("zero_r1", 1'b0, 4'd1, ZeroR1);
    read_rk("zero_r2", 1'b0, 4'd2, ZeroR2);
    read_rk("zero_dec_r10", 1'b1, 4'd10, 128'd0);

    // 6: reset mid-EXPAND with key_valid asserted on the reset edge
    bus.key_in    = KeyFips;
    bus.key_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("mid_busy", 128'(bus.busy), 128'd1);
    rst_n         = 1'b0;
    bus.key_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.key_valid = 1'b0;
    check_eq("abort_kv", 128'(bus.keys_valid), 128'd0);
    check_eq("abort_rdy", 128'(bus.key_ready), 128'd1);
    check_eq("abort_busy", 128'(bus.busy), 128'd0);
    repeat (12) @(posedge clk);
    #1;
    check_eq("abort_kv_late", 128'(bus.keys_valid), 128'd0);
    check_eq("abort_busy_late", 128'(bus.busy), 128'd0);

    load_key("fresh", KeyFips, 0);
    read_rk("fresh_r1", 1'b0, 4'd1, FipsR1);
    read_rk("fresh_r10", 1'b0, 4'd10, FipsR10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
